// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: VGA prefetch reads take priority, CPU writes fill the rest.
// Optional sticky underflow flag built only when VGA_ARB_UNDERFLOW_EN is defined.
module vga_fb_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [23:0]       cpu_wr_data,
  input  logic              vga_valid,
  input  logic              vga_vsync,
  output logic [23:0]       vga_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [23:0]       ram_wdata,
  input  logic [23:0]       ram_rdata,
  output logic              underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(H_RES * V_RES);
  localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [PW:0]       level_q, level_d;
  logic              infl_q, infl_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [23:0]       mem_q [FIFO_DEPTH];

  logic need_fetch;
  logic push;
  logic pop;
  logic empty;

  assign empty = (level_q == '0);
  assign push  = infl_q & vga_vsync;
  assign pop   = vga_valid & ~empty;

  // Reserve a slot for the read still in flight so a push never overflows.
  assign need_fetch = vga_vsync & ~reset & (fetch_q < FRAME)
                    & ((level_q + {{PW{1'b0}}, infl_q}) < DEPTH);

  assign cpu_wr_ready = ~need_fetch & ~reset;
  assign vga_data = (~empty & ~reset) ? mem_q[rptr_q] : 24'h0;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 24'h0;
    fetch_d   = fetch_q;
    infl_d    = need_fetch;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    if (need_fetch) begin
      ram_en   = 1'b1;
      ram_addr = fetch_q;
      fetch_d  = fetch_q + 1'b1;
    end else if (cpu_wr_valid && cpu_wr_ready) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = cpu_wr_addr;
      ram_wdata = cpu_wr_data;
    end
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    level_d = level_q + (PW+1)'(push) - (PW+1)'(pop);
    if (!vga_vsync) begin
      fetch_d = '0;
      infl_d  = 1'b0;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      fetch_q <= '0;
      level_q <= '0;
      infl_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      fetch_q <= fetch_d;
      level_q <= level_d;
      infl_q  <= infl_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem_q[wptr_q] <= ram_rdata;
  end

`ifdef VGA_ARB_UNDERFLOW_EN
  logic uflow_q;

  always_ff @(posedge pclk) begin
    if (reset) begin
      uflow_q <= 1'b0;
    end else if (vga_valid && empty) begin
      uflow_q <= 1'b1;
    end
  end

  assign underflow = uflow_q;
`else
  assign underflow = 1'b0;
`endif

endmodule
